// File: rtl/full_addr.sv
// rtl/full_addr.sv - ripple-carry full adder with optional output register stage (FULL_ADDR_REG_OUT_EN)

// One-bit full-adder cell: the building block of the ripple chain
module full_addr_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module full_addr #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic             Cin,
    input  logic             En,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q,
    output logic             Ovf_q,
    output logic             Vld_q
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out
    logic [WIDTH:0] carry;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            full_addr_cell u_cell (
                .a_i (Ain[i]),
                .b_i (Bin[i]),
                .c_i (carry[i]),
                .s_o (Sum[i]),
                .c_o (carry[i+1])
            );
        end
    endgenerate

    assign Cout = carry[WIDTH];
    // Signed overflow: carry into the MSB disagrees with carry out of it
    assign Ovf  = carry[WIDTH-1] ^ carry[WIDTH];

`ifdef FULL_ADDR_REG_OUT_EN

    logic [WIDTH-1:0] sum_reg_d,  sum_reg_q;
    logic             cout_reg_d, cout_reg_q;
    logic             ovf_reg_d,  ovf_reg_q;
    logic             vld_reg_d,  vld_reg_q;

    // Next state: capture the live adder result when En is high, otherwise hold
    always_comb begin
        sum_reg_d  = sum_reg_q;
        cout_reg_d = cout_reg_q;
        ovf_reg_d  = ovf_reg_q;
        vld_reg_d  = vld_reg_q;
        if (En) begin
            sum_reg_d  = Sum;
            cout_reg_d = Cout;
            ovf_reg_d  = Ovf;
            vld_reg_d  = 1'b1;
        end
    end

    // Result register; Rst clears it immediately and overrides En
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sum_reg_q  <= '0;
            cout_reg_q <= 1'b0;
            ovf_reg_q  <= 1'b0;
            vld_reg_q  <= 1'b0;
        end else begin
            sum_reg_q  <= sum_reg_d;
            cout_reg_q <= cout_reg_d;
            ovf_reg_q  <= ovf_reg_d;
            vld_reg_q  <= vld_reg_d;
        end
    end

    assign Sum_q  = sum_reg_q;
    assign Cout_q = cout_reg_q;
    assign Ovf_q  = ovf_reg_q;
    assign Vld_q  = vld_reg_q;

`else

    // Registered stage not built: outputs are constant and the clock/control pins are unused
    assign Sum_q  = '0;
    assign Cout_q = 1'b0;
    assign Ovf_q  = 1'b0;
    assign Vld_q  = 1'b0;

    logic unused_reg_ctrl;
    assign unused_reg_ctrl = Clk ^ Rst ^ En;

`endif

endmodule

// File: tb/tb_full_addr.sv
// tb/tb_full_addr.sv - scoreboard testbench for full_addr (WIDTH=1 and WIDTH=8 instances)
module tb_full_addr;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       a1, b1, c1, en1;
    logic       s1, co1, ov1, sq1, coq1, ovq1, vq1;
    logic [7:0] a8, b8, s8, sq8;
    logic       c8, en8, co8, ov8, coq8, ovq8, vq8;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {ovf, cout, sum} entries, pushed at stimulus time
    logic [2:0] sb1_q[$];
    logic [9:0] sb8_q[$];
    logic [9:0] sb8_reg_q[$];

    full_addr #(.WIDTH(1)) u_dut1 (
        .Clk(clk), .Rst(rst), .Ain(a1), .Bin(b1), .Cin(c1), .En(en1),
        .Sum(s1), .Cout(co1), .Ovf(ov1),
        .Sum_q(sq1), .Cout_q(coq1), .Ovf_q(ovq1), .Vld_q(vq1)
    );

    full_addr #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Rst(rst), .Ain(a8), .Bin(b8), .Cin(c8), .En(en8),
        .Sum(s8), .Cout(co8), .Ovf(ov8),
        .Sum_q(sq8), .Cout_q(coq8), .Ovf_q(ovq8), .Vld_q(vq8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
        logic [1:0] t;
        t = {1'b0, a} + {1'b0, b} + {1'b0, c};
        return {(a == b) && (t[0] != a), t[1], t[0]};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b} + {8'b0, c};
        return {(a[7] == b[7]) && (t[7] != a[7]), t[8], t[7:0]};
    endfunction

    task automatic comb1(input logic a, input logic b, input logic c, input string tag);
        logic [2:0] e;
        a1 = a; b1 = b; c1 = c;
        sb1_q.push_back(model1(a, b, c));
        #5;
        e = sb1_q.pop_front();
        check({tag, "_sum"},  64'(s1),  64'(e[0]));
        check({tag, "_cout"}, 64'(co1), 64'(e[1]));
        check({tag, "_ovf"},  64'(ov1), 64'(e[2]));
    endtask

    task automatic comb8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
        logic [9:0] e;
        a8 = a; b8 = b; c8 = c;
        sb8_q.push_back(model8(a, b, c));
        #5;
        e = sb8_q.pop_front();
        check({tag, "_sum"},  64'(s8),  64'(e[7:0]));
        check({tag, "_cout"}, 64'(co8), 64'(e[8]));
        check({tag, "_ovf"},  64'(ov8), 64'(e[9]));
    endtask

    task automatic chk_reg8(input string tag, input logic [9:0] e, input logic v);
        check({tag, "_sum_q"},  64'(sq8),  64'(e[7:0]));
        check({tag, "_cout_q"}, 64'(coq8), 64'(e[8]));
        check({tag, "_ovf_q"},  64'(ovq8), 64'(e[9]));
        check({tag, "_vld_q"},  64'(vq8),  64'(v));
    endtask

    initial begin
        logic [9:0] e;
        logic [9:0] last;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; en1 = 1'b0;
        a8 = '0;   b8 = '0;   c8 = 1'b0; en8 = 1'b0;

        #1;
        chk_reg8("reset8", 10'd0, 1'b0);
        check("reset1_vld_q", 64'(vq1), 64'(0));
        check("reset1_sum_q", 64'(sq1), 64'(0));

        // Combinational checks run with Rst held high: Rst must not disturb them
        comb1(1'b0, 1'b1, 1'b1, "w1_011");
        comb1(1'b1, 1'b1, 1'b0, "w1_110");
        comb1(1'b1, 1'b1, 1'b1, "w1_111");
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            comb1(v[2], v[1], v[0], $sformatf("w1_sweep%0d", k));
        end
        comb8(8'hFF, 8'h00, 1'b1, "w8_ff_00_1");
        comb8(8'h7F, 8'h01, 1'b0, "w8_7f_01_0");
        comb8(8'hFF, 8'hFF, 1'b1, "w8_max");
        comb8(8'h80, 8'h80, 1'b0, "w8_negovf");
        for (int k = 0; k < 12; k++)
            comb8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("w8_rand%0d", k));

        @(negedge clk);
        rst = 1'b0;

`ifdef FULL_ADDR_REG_OUT_EN
        // Single-cycle load pulse
        a8 = 8'h01; b8 = 8'h00; c8 = 1'b0; en8 = 1'b1;
        sb8_reg_q.push_back(model8(a8, b8, c8));
        @(posedge clk); #1;
        en8 = 1'b0;
        last = sb8_reg_q.pop_front();
        chk_reg8("load", last, 1'b1);
        check("w1_idle_vld_q", 64'(vq1), 64'(0));

        // Hold with En low while inputs move
        a8 = 8'h55; b8 = 8'h22; c8 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk_reg8("hold", last, 1'b1);

        // Random enable pattern
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            en8 = 1'($urandom_range(0, 1));
            if (en8) sb8_reg_q.push_back(model8(a8, b8, c8));
            @(posedge clk); #1;
            if (en8) last = sb8_reg_q.pop_front();
            chk_reg8($sformatf("rand%0d", k), last, 1'b1);
        end

        // Asynchronous reset between edges, with En high
        @(negedge clk); #2;
        rst = 1'b1; en8 = 1'b1;
        #1;
        chk_reg8("rst_async", 10'd0, 1'b0);
        comb8(8'h3C, 8'h4D, 1'b1, "rst_comb");
        @(posedge clk); #1;
        chk_reg8("rst_prio", 10'd0, 1'b0);

        // First enabled edge after reset release
        @(negedge clk);
        rst = 1'b0;
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; en8 = 1'b1;
        sb8_reg_q.push_back(model8(a8, b8, c8));
        @(posedge clk); #1;
        en8 = 1'b0;
        e = sb8_reg_q.pop_front();
        chk_reg8("post_rst", e, 1'b1);
`else
        // Registered stage absent: outputs stay tied low even with En active
        en1 = 1'b1; en8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
            @(posedge clk); #1;
            chk_reg8($sformatf("tied%0d", k), 10'd0, 1'b0);
            check($sformatf("tied1_%0d", k), 64'({ovq1, coq1, sq1, vq1}), 64'(0));
        end
        en1 = 1'b0; en8 = 1'b0;
        e = 10'd0;
        last = e;
`endif

        check("sb_empty", 64'(sb1_q.size() + sb8_q.size() + sb8_reg_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
